// File: rtl/pool2d_stream.sv
// Streaming non-overlapping 2-D max/average pooling over a raster-scan feature map.
// One partial accumulator per window column group; a single output register carries the result.
module pool2d_stream #(
    parameter int DATA_WIDTH   = 16,
    parameter int CHANNELS     = 1,
    parameter int IMAGE_HEIGHT = 28,
    parameter int IMAGE_WIDTH  = 28,
    parameter int POOL_H       = 2,
    parameter int POOL_W       = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           avg_mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           out_last
);

    localparam int SHIFT  = $clog2(POOL_H * POOL_W);
    localparam int ACC_W  = DATA_WIDTH + SHIFT;
    localparam int GROUPS = IMAGE_WIDTH / POOL_W;
    localparam int RW     = $clog2(IMAGE_HEIGHT + 1);
    localparam int CW     = $clog2(IMAGE_WIDTH + 1);
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if ((IMAGE_HEIGHT % POOL_H) != 0) begin : g_bad_height
        $error("pool2d_stream: IMAGE_HEIGHT must be a multiple of POOL_H");
    end
    if ((IMAGE_WIDTH % POOL_W) != 0) begin : g_bad_width
        $error("pool2d_stream: IMAGE_WIDTH must be a multiple of POOL_W");
    end
    if ((POOL_H < 1) || ((POOL_H & (POOL_H - 1)) != 0) ||
        (POOL_W < 1) || ((POOL_W & (POOL_W - 1)) != 0)) begin : g_bad_pool
        $error("pool2d_stream: POOL_H and POOL_W must be powers of two");
    end

    logic [RW-1:0]                  row_r;
    logic [CW-1:0]                  col_r;
    logic                           mode_r;
    logic                           out_valid_r;
    logic                           out_last_r;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data_r;
    logic signed [ACC_W-1:0]        part_r [GROUPS][CHANNELS];

    logic                           xfer_s;
    logic                           frame_start_s;
    logic                           first_s;
    logic                           emit_s;
    logic                           last_px_s;
    logic                           mode_s;
    logic [GW-1:0]                  grp_s;
    logic signed [ACC_W-1:0]        pix_ext_s [CHANNELS];
    logic signed [ACC_W-1:0]        cur_s     [CHANNELS];
    logic signed [ACC_W-1:0]        comb_s    [CHANNELS];
    logic [CHANNELS*DATA_WIDTH-1:0] res_s;

    // Handshake and window-position decode.
    always_comb begin
        in_ready      = !out_valid_r || out_ready;
        xfer_s        = in_valid && in_ready;
        frame_start_s = (row_r == {RW{1'b0}}) && (col_r == {CW{1'b0}});
        first_s       = ((row_r % RW'(POOL_H)) == {RW{1'b0}}) &&
                        ((col_r % CW'(POOL_W)) == {CW{1'b0}});
        emit_s        = ((row_r % RW'(POOL_H)) == RW'(POOL_H - 1)) &&
                        ((col_r % CW'(POOL_W)) == CW'(POOL_W - 1));
        last_px_s     = (row_r == RW'(IMAGE_HEIGHT - 1)) && (col_r == CW'(IMAGE_WIDTH - 1));
        // The frame's first pixel uses the live mode bit, since it is latched on that same edge.
        mode_s        = frame_start_s ? avg_mode : mode_r;
        grp_s         = GW'(col_r / CW'(POOL_W));
    end

    // Per-lane combine of the incoming pixel with its window partial, and the pooled result.
    always_comb begin
        res_s = {(CHANNELS*DATA_WIDTH){1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            pix_ext_s[c] = ACC_W'($signed(in_data[c*DATA_WIDTH +: DATA_WIDTH]));
            cur_s[c]     = part_r[grp_s][c];
            if (first_s) begin
                comb_s[c] = pix_ext_s[c];
            end else if (mode_s) begin
                comb_s[c] = cur_s[c] + pix_ext_s[c];
            end else if (pix_ext_s[c] > cur_s[c]) begin
                comb_s[c] = pix_ext_s[c];
            end else begin
                comb_s[c] = cur_s[c];
            end
            if (mode_s) begin
                res_s[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(comb_s[c] >>> SHIFT);
            end else begin
                res_s[c*DATA_WIDTH +: DATA_WIDTH] = comb_s[c][DATA_WIDTH-1:0];
            end
        end
    end

    // Raster position counters and per-frame mode latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_r  <= {RW{1'b0}};
            col_r  <= {CW{1'b0}};
            mode_r <= 1'b0;
        end else if (xfer_s) begin
            if (frame_start_s) begin
                mode_r <= avg_mode;
            end
            if (col_r == CW'(IMAGE_WIDTH - 1)) begin
                col_r <= {CW{1'b0}};
                row_r <= (row_r == RW'(IMAGE_HEIGHT - 1)) ? {RW{1'b0}} : row_r + RW'(1);
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Partial buffer; the first pixel of each window overwrites, so no reset is required.
    always_ff @(posedge clock) begin
        if (xfer_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
                part_r[grp_s][c] <= comb_s[c];
            end
        end
    end

    // Output register: loads on a window-completing transfer, otherwise drains on handoff.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {(CHANNELS*DATA_WIDTH){1'b0}};
        end else if (xfer_s && emit_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= last_px_s;
            out_data_r  <= res_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream on a 4x4, 2-lane map with 2x2 windows,
// checked against a window-level reference model plus literal expectations.
module tb_pool2d_stream;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int NPIX = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            avg_mode = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CH*DW-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [CH*DW-1:0] out_data;
    logic            out_last;

    int checks = 0;
    int failures = 0;
    int cur0 [NPIX];
    int cur1 [NPIX];
    logic [CH*DW:0] exp_q [$];
    int obs0 [$];
    int obs1 [$];
    int last_cnt = 0;
    int m_pos = 0;
    bit lat_pend = 1'b0;
    bit prev_stall = 1'b0;
    logic [CH*DW:0] prev_out = '0;

    always #5 clock = ~clock;

    pool2d_stream #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .IMAGE_HEIGHT(4), .IMAGE_WIDTH(4),
        .POOL_H(2), .POOL_W(2)
    ) dut (
        .clock(clock), .reset(reset), .avg_mode(avg_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    // Reference: pooled pixels of the current frame arrays, in raster window order.
    task automatic model_push(input bit mode);
        for (int wy = 0; wy < 2; wy++) begin
            for (int wx = 0; wx < 2; wx++) begin
                logic [CH*DW:0] e;
                e = '0;
                for (int c = 0; c < CH; c++) begin
                    int sum, mx, v, res;
                    sum = 0;
                    mx = -1000000;
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            int idx;
                            idx = (2*wy + dy) * 4 + 2*wx + dx;
                            v = (c == 0) ? cur0[idx] : cur1[idx];
                            sum += v;
                            if (v > mx) mx = v;
                        end
                    end
                    if (mode) begin
                        res = sum / 4;
                        if ((sum % 4 != 0) && (sum < 0)) res = res - 1;
                    end else begin
                        res = mx;
                    end
                    e[c*DW +: DW] = res[DW-1:0];
                end
                e[CH*DW] = (wy == 1) && (wx == 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_frame(input bit mode, input bit toggle, input int npix);
        if (npix == NPIX) model_push(mode);
        for (int p = 0; p < npix; p++) begin
            int k;
            bit got;
            avg_mode = (toggle && p >= 6) ? !mode : mode;
            in_valid = 1'b1;
            in_data  = {cur1[p][DW-1:0], cur0[p][DW-1:0]};
            k = 0;
            got = 1'b0;
            while (!got && k < 200) begin
                @(negedge clock);
                if (in_ready) got = 1'b1;
                @(posedge clock);
                #1;
                k++;
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL accept_timeout pixel=%0d actual=in_ready_low required=accepted", p);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic check_obs(input string nm, input int e0, input int e1, input int e2, input int e3);
        int ex [4];
        ex = '{e0, e1, e2, e3};
        checks++;
        if (obs0.size() < 4) begin
            failures++;
            $display("FAIL %s_count actual=%0d required>=4", nm, obs0.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                int v;
                v = obs0.pop_front();
                void'(obs1.pop_front());
                checks++;
                if (v != ex[i]) begin
                    failures++;
                    $display("FAIL %s[%0d] actual=%0d required=%0d", nm, i, v, ex[i]);
                end
            end
        end
    endtask

    task automatic check_lane1_first(input string nm, input int req);
        checks++;
        if (obs1.size() == 0 || obs1[0] != req) begin
            failures++;
            $display("FAIL %s_lane1 actual=%0d required=%0d", nm,
                     (obs1.size() == 0) ? 0 : obs1[0], req);
        end
    endtask

    task automatic set_frame_a();
        cur0 = '{8, 1, 5, 3, 6, 7, 2, 4, 9, 0, 3, 2, 1, 5, 6, 8};
        for (int i = 0; i < NPIX; i++) cur1[i] = cur0[i] - 5;
    endtask

    task automatic set_frame_neg();
        cur0 = '{-1, -2, 5, 6, -3, -4, 7, 8, 0, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < NPIX; i++) cur1[i] = -32768;
    endtask

    // Per-cycle monitor: handshake rule, latency, stall stability and scoreboard compare.
    always @(negedge clock) begin : mon
        logic [CH*DW:0] e;
        int r, c;
        if (reset) begin
            m_pos = 0;
            lat_pend = 1'b0;
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                failures++;
                $display("FAIL in_ready_rule actual=%b required=%b", in_ready, !out_valid || out_ready);
            end
            if (lat_pend) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL latency actual=out_valid_%b required=1", out_valid);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {out_last, out_data} !== prev_out) begin
                    failures++;
                    $display("FAIL stall_hold actual=%h required=%h", {out_last, out_data}, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out actual=%h required=none", {out_last, out_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        failures++;
                        $display("FAIL pooled_pixel actual=%h required=%h", {out_last, out_data}, e);
                    end
                end
                obs0.push_back(int'($signed(out_data[DW-1:0])));
                obs1.push_back(int'($signed(out_data[2*DW-1:DW])));
                if (out_last) last_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {out_last, out_data};
            lat_pend = 1'b0;
            if (in_valid && in_ready) begin
                r = m_pos / 4;
                c = m_pos % 4;
                lat_pend = (r % 2 == 1) && (c % 2 == 1);
                m_pos = (m_pos + 1) % NPIX;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
        if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last actual=%b required=0", out_last); end
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data actual=%h required=0", out_data); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
        @(posedge clock);
        #1;

        set_frame_a();
        send_frame(1'b0, 1'b0, NPIX);
        drain();
        check_obs("t1_max", 8, 5, 9, 8);

        send_frame(1'b1, 1'b0, NPIX);
        drain();
        check_obs("t2_avg", 5, 3, 3, 4);

        set_frame_neg();
        send_frame(1'b1, 1'b0, NPIX);
        drain();
        check_lane1_first("t3_avg", -32768);
        check_obs("t3_avg", -3, 6, 0, 0);
        send_frame(1'b0, 1'b0, NPIX);
        drain();
        check_lane1_first("t3_max", -32768);
        check_obs("t3_max", -1, 8, 1, 1);

        set_frame_a();
        out_ready = 1'b0;
        fork
            send_frame(1'b0, 1'b0, NPIX);
            begin : stall
                int k;
                k = 0;
                while (!out_valid && k < 100) begin
                    @(negedge clock);
                    k++;
                end
                checks++;
                if (!out_valid) begin
                    failures++;
                    $display("FAIL t4_first_out actual=no_valid required=valid");
                end
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clock);
                    checks++;
                    if (in_ready !== 1'b0 || out_data[DW-1:0] !== 16'd8) begin
                        failures++;
                        $display("FAIL t4_stall cycle=%0d actual=ready_%b_data_%0d required=ready_0_data_8",
                                 i, in_ready, out_data[DW-1:0]);
                    end
                end
                @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_obs("t4_bp", 8, 5, 9, 8);

        send_frame(1'b0, 1'b0, NPIX);
        send_frame(1'b1, 1'b1, NPIX);
        drain();
        check_obs("t5_a", 8, 5, 9, 8);
        check_obs("t5_b", 5, 3, 3, 4);

        out_ready = 1'b0;
        send_frame(1'b0, 1'b0, 6);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL t6_reset_drop actual=valid_%b_last_%b required=0_0", out_valid, out_last);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        send_frame(1'b0, 1'b0, NPIX);
        drain();
        check_obs("t6_after_reset", 8, 5, 9, 8);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
        end
        checks++;
        if (last_cnt != 8) begin
            failures++;
            $display("FAIL out_last_count actual=%0d required=8", last_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
